// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and helpers for the debounce_edge block.
//   db_state_t   - debounce FSM state encoding
//   cnt_width()  - width of the stability counter for a given STABLE_CYCLES
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHK_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    CHK_LOW     = 2'd3
  } db_state_t;

  // The counter must be able to hold values up to STABLE_CYCLES.
  // It is never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_edge_stable_counter.sv
// stable_counter: counts consecutive samples of a candidate level.
// Ports:
//   clk      - system clock, posedge
//   reset    - synchronous active-high reset, count -> 0
//   clr      - synchronous clear, count -> 0 (wins over en)
//   en       - increment the count by one
//   at_limit - high while count == STABLE_CYCLES-1. The sample taken in
//              that state is the STABLE_CYCLES-th consecutive one.
module stable_counter
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam int W = cnt_width(STABLE_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(STABLE_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // With STABLE_CYCLES=1, LIMIT is 0. at_limit is then always high, so
  // the first differing sample is accepted immediately.
  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: glitch filter and edge detector for an already
// synchronized input. A new level is accepted only after STABLE_CYCLES
// consecutive identical samples.
// Ports:
//   clk        - system clock, posedge
//   reset      - synchronous active-high reset (dominates all inputs)
//   sync_in    - synchronized input level
//   clear      - synchronous clear of edge_count only
//   db_out     - debounced level (registered)
//   rise_pulse - one-cycle pulse after an accepted 0->1 change (registered)
//   fall_pulse - one-cycle pulse after an accepted 1->0 change (registered)
//   edge_count - saturating count of accepted rises (registered)
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_BITS      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sync_in,
  input  logic                clear,
  output logic                db_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [CNT_BITS-1:0] edge_count
);

  db_state_t state;
  logic      at_limit;
  logic      cnt_en;
  logic      cnt_clr;
  logic      low_side;
  logic      candidate;
  logic      rise_accept;
  logic      fall_accept;

  // low_side: the FSM is in STABLE_LOW or CHK_HIGH, so the accepted level
  // is 0. candidate: the current sample differs from the accepted level.
  assign low_side    = (state == STABLE_LOW) || (state == CHK_HIGH);
  assign candidate   = low_side ? sync_in : ~sync_in;
  assign rise_accept = low_side && sync_in && at_limit;
  assign fall_accept = !low_side && !sync_in && at_limit;

  // The counter advances on every differing sample until acceptance.
  // It drops to zero on a matching sample or when a level is accepted.
  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    if (candidate && !at_limit) begin
      cnt_en  = 1'b1;
      cnt_clr = 1'b0;
    end
  end

  stable_counter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stable_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STABLE_LOW;
      db_out     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      edge_count <= '0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;

      case (state)
        STABLE_LOW: begin
          if (rise_accept) begin
            state      <= STABLE_HIGH;
            db_out     <= 1'b1;
            rise_pulse <= 1'b1;
          end else if (sync_in) begin
            state <= CHK_HIGH;
          end
        end
        CHK_HIGH: begin
          if (!sync_in) begin
            state <= STABLE_LOW;
          end else if (rise_accept) begin
            state      <= STABLE_HIGH;
            db_out     <= 1'b1;
            rise_pulse <= 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (fall_accept) begin
            state      <= STABLE_LOW;
            db_out     <= 1'b0;
            fall_pulse <= 1'b1;
          end else if (!sync_in) begin
            state <= CHK_LOW;
          end
        end
        CHK_LOW: begin
          if (sync_in) begin
            state <= STABLE_HIGH;
          end else if (fall_accept) begin
            state      <= STABLE_LOW;
            db_out     <= 1'b0;
            fall_pulse <= 1'b1;
          end
        end
        default: begin
          state <= STABLE_LOW;
        end
      endcase

      // clear beats a coincident rise. A saturated count holds at all ones.
      if (clear) begin
        edge_count <= '0;
      end else if (rise_accept && (edge_count != '1)) begin
        edge_count <= edge_count + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge. There are three instances:
//   dut_a: STABLE_CYCLES=4, CNT_BITS=8
//   dut_b: STABLE_CYCLES=4, CNT_BITS=2 (saturation)
//   dut_c: STABLE_CYCLES=1, CNT_BITS=8 (immediate acceptance)
// dut_a and dut_b share all inputs. dut_c shares reset and clear but has
// its own level input.
module tb_debounce_edge;

  logic       clk;
  logic       reset;
  logic       sync_in;
  logic       sync_c;
  logic       clear;

  logic       db_a, rise_a, fall_a;
  logic [7:0] cnt_a;
  logic       db_b, rise_b, fall_b;
  logic [1:0] cnt_b;
  logic       db_c, rise_c, fall_c;
  logic [7:0] cnt_c;

  int n_cmp;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  debounce_edge #(.STABLE_CYCLES(4), .CNT_BITS(8)) dut_a (
    .clk(clk), .reset(reset), .sync_in(sync_in), .clear(clear),
    .db_out(db_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .edge_count(cnt_a)
  );

  debounce_edge #(.STABLE_CYCLES(4), .CNT_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .sync_in(sync_in), .clear(clear),
    .db_out(db_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .edge_count(cnt_b)
  );

  debounce_edge #(.STABLE_CYCLES(1), .CNT_BITS(8)) dut_c (
    .clk(clk), .reset(reset), .sync_in(sync_c), .clear(clear),
    .db_out(db_c), .rise_pulse(rise_c), .fall_pulse(fall_c), .edge_count(cnt_c)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ab(input string tag, input logic db, input logic rise,
                          input logic fall, input logic [7:0] ea, input logic [1:0] eb);
    check({tag, " db_a"},   db_a,   db);
    check({tag, " rise_a"}, rise_a, rise);
    check({tag, " fall_a"}, fall_a, fall);
    check({tag, " cnt_a"},  cnt_a,  ea);
    check({tag, " db_b"},   db_b,   db);
    check({tag, " rise_b"}, rise_b, rise);
    check({tag, " fall_b"}, fall_b, fall);
    check({tag, " cnt_b"},  cnt_b,  eb);
  endtask

  // Drive a new level for 4 edges on the shared input. Expect no change
  // for 3 edges, then acceptance. One more edge with the level held
  // confirms the pulse lasts only one cycle.
  task automatic do_change(input string tag, input logic lvl,
                           input logic [7:0] ea_before, input logic [1:0] eb_before,
                           input logic [7:0] ea, input logic [1:0] eb);
    sync_in = lvl;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ab({tag, " wait"}, ~lvl, 1'b0, 1'b0, ea_before, eb_before);
    end
    step();
    check_ab({tag, " accept"}, lvl, lvl, ~lvl, ea, eb);
    step();
    check_ab({tag, " after"}, lvl, 1'b0, 1'b0, ea, eb);
  endtask

  // ---------------- scenario ----------------
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    sync_in = 1'b1;
    sync_c  = 1'b0;
    clear   = 1'b0;

    // Test 1: reset dominates a high input, then 4 edges to accept.
    step();
    step();
    check_ab("reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    check("reset db_c", db_c, 1'b0);
    check("reset cnt_c", cnt_c, 8'd0);
    reset = 1'b0;
    do_change("t1 rise", 1'b1, 8'd0, 2'd0, 8'd1, 2'd1);

    // Test 4: fall from STABLE_HIGH, edge_count unchanged.
    do_change("t4 fall", 1'b0, 8'd1, 2'd1, 8'd1, 2'd1);

    // Test 2: 0->1 held 10 cycles. 5 are covered by do_change, 5 more here.
    do_change("t2 rise", 1'b1, 8'd1, 2'd1, 8'd2, 2'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check_ab("t2 hold", 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);
    end
    do_change("t2 fall", 1'b0, 8'd2, 2'd2, 8'd2, 2'd2);

    // Test 3: 3-cycle glitches are filtered completely, five times.
    for (int r = 0; r < 5; r++) begin
      sync_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        check_ab("t3 glitch hi", 1'b0, 1'b0, 1'b0, 8'd2, 2'd2);
      end
      sync_in = 1'b0;
      step();
      check_ab("t3 glitch lo", 1'b0, 1'b0, 1'b0, 8'd2, 2'd2);
    end

    // A glitch low from STABLE_HIGH is filtered the same way.
    do_change("t3b rise", 1'b1, 8'd2, 2'd2, 8'd3, 2'd3);
    sync_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ab("t3b glitch lo", 1'b1, 1'b0, 1'b0, 8'd3, 2'd3);
    end
    sync_in = 1'b1;
    step();
    check_ab("t3b glitch hi", 1'b1, 1'b0, 1'b0, 8'd3, 2'd3);
    do_change("t3b fall", 1'b0, 8'd3, 2'd3, 8'd3, 2'd3);

    // Test 5: clear with no rise, then five rises. dut_b reads 1,2,3,3,3.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_ab("t5 clear", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    do_change("t5 r1", 1'b1, 8'd0, 2'd0, 8'd1, 2'd1);
    do_change("t5 f1", 1'b0, 8'd1, 2'd1, 8'd1, 2'd1);
    do_change("t5 r2", 1'b1, 8'd1, 2'd1, 8'd2, 2'd2);
    do_change("t5 f2", 1'b0, 8'd2, 2'd2, 8'd2, 2'd2);
    do_change("t5 r3", 1'b1, 8'd2, 2'd2, 8'd3, 2'd3);
    do_change("t5 f3", 1'b0, 8'd3, 2'd3, 8'd3, 2'd3);
    do_change("t5 r4", 1'b1, 8'd3, 2'd3, 8'd4, 2'd3);
    do_change("t5 f4", 1'b0, 8'd4, 2'd3, 8'd4, 2'd3);
    do_change("t5 r5", 1'b1, 8'd4, 2'd3, 8'd5, 2'd3);
    do_change("t5 f5", 1'b0, 8'd5, 2'd3, 8'd5, 2'd3);

    // Test 6a: clear on the acceptance edge. The count goes to 0 and the
    // pulse still fires.
    sync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ab("t6 wait", 1'b0, 1'b0, 1'b0, 8'd5, 2'd3);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_ab("t6 clear+rise", 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
    do_change("t6 fall", 1'b0, 8'd0, 2'd0, 8'd0, 2'd0);

    // Test 6b: reset after 2 high samples. The check is abandoned with
    // no pulse, and a full 4-edge run is needed afterwards.
    sync_in = 1'b1;
    step();
    step();
    check_ab("t6 pre-reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_ab("t6 reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    do_change("t6 rerun", 1'b1, 8'd0, 2'd0, 8'd1, 2'd1);

    // STABLE_CYCLES=1: each level change is accepted on its first sample.
    sync_c = 1'b1;
    step();
    check("c rise db", db_c, 1'b1);
    check("c rise pulse", rise_c, 1'b1);
    check("c rise cnt", cnt_c, 8'd1);
    sync_c = 1'b0;
    step();
    check("c fall db", db_c, 1'b0);
    check("c fall pulse", fall_c, 1'b1);
    check("c fall no rise", rise_c, 1'b0);
    sync_c = 1'b1;
    step();
    check("c rise2 pulse", rise_c, 1'b1);
    check("c rise2 cnt", cnt_c, 8'd2);
    step();
    check("c hold pulse", rise_c, 1'b0);
    check("c hold db", db_c, 1'b1);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
